// File: rtl/axis_adc_pkg.sv
// axis_adc_pkg: lane width, sample decode and decimation clamp shared by the ADC front end
package axis_adc_pkg;
  localparam int LANE_W = 16;
  function automatic logic [LANE_W-1:0] decode(input logic [LANE_W-1:0] raw, input int w,
                                               input logic derand, input logic offset_bin);
    logic [LANE_W-1:0] v;
    v = raw;
    for (int i = 1; i < LANE_W; i++) if (derand && i < w) v[4'(i)] = raw[4'(i)] ^ raw[0];
    if (offset_bin) v[4'(w-1)] = ~v[4'(w-1)];
    for (int i = 0; i < LANE_W; i++) if (i >= w) v[4'(i)] = v[4'(w-1)];
    return v;
  endfunction
  function automatic logic [3:0] clamp_d(input logic [3:0] d, input int max_d);
    return (int'(d) > max_d) ? 4'(max_d) : d;
  endfunction
endpackage

// File: rtl/axis_adc_multich_if.sv
// axis_adc_multich_if: AXI-Stream result bus carrying N_CH sign-extended 16-bit lanes
interface axis_adc_multich_if #(parameter int N_CH = 2) ();
  import axis_adc_pkg::*;
  logic tready;
  logic tvalid;
  logic [N_CH*LANE_W-1:0] tdata;
  modport master(input tready, output tvalid, output tdata);
  modport slave(output tready, input tvalid, input tdata);
endinterface

// File: rtl/axis_adc_lane.sv
// axis_adc_lane: one channel's decode, input register, window accumulator and averaging shift
module axis_adc_lane
  import axis_adc_pkg::*;
#(
  parameter int W = 14,
  parameter int A = 22
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              derand,
  input  logic              offset_bin,
  input  logic              first,
  input  logic [3:0]        shift,
  input  logic [W-1:0]      dat,
  output logic [LANE_W-1:0] res
);
  logic signed [W-1:0] in_q;
  logic signed [A-1:0] acc;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      in_q <= '0;
      acc  <= '0;
    end else begin
      in_q <= W'(decode(LANE_W'(dat), W, derand, offset_bin));
      acc  <= first ? A'(in_q) : acc + A'(in_q);
    end
  // arithmetic shift floors toward -inf, giving the block average
  assign res = LANE_W'(acc >>> shift);
endmodule

// File: rtl/axis_adc_multich.sv
// axis_adc_multich: N_CH ADC capture with optional 2^D block averaging onto an AXI-Stream master
module axis_adc_multich
  import axis_adc_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 14,
  parameter int N_CH = 2,
  parameter int MAX_LOG2_DEC = 8
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           cfg_derand,
  input  logic                           cfg_offset_bin,
  input  logic [3:0]                     cfg_log2_dec,
  input  logic [N_CH*ADC_DATA_WIDTH-1:0] adc_dat,
  output logic                           adc_csn,
  axis_adc_multich_if.master             m_axis,
  output logic [31:0]                    sts_overflow_cnt
);
  localparam int CW = MAX_LOG2_DEC + 1;
  logic [CW-1:0] cnt;
  logic [3:0] d_cur, d1, d2;
  logic first1, last1, done2, last, load;
  logic [N_CH*LANE_W-1:0] res;
  assign adc_csn = 1'b1;
  // D is only re-read at window start; otherwise the window keeps its latched value
  always_comb begin
    d_cur = (cnt == '0) ? clamp_d(cfg_log2_dec, MAX_LOG2_DEC) : d1;
    last  = cnt == (CW'(1) << d_cur) - CW'(1);
    load  = done2 && (!m_axis.tvalid || m_axis.tready);
  end
  // control flags travel alongside the samples: stage 1 with the input register, stage 2 with the accumulator
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      cnt    <= '0;
      d1     <= '0;
      d2     <= '0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      done2  <= 1'b0;
    end else begin
      cnt    <= last ? '0 : cnt + 1'b1;
      d1     <= d_cur;
      first1 <= cnt == '0;
      last1  <= last;
      done2  <= last1;
      d2     <= d1;
    end
  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    axis_adc_lane #(.W(ADC_DATA_WIDTH), .A(ADC_DATA_WIDTH + MAX_LOG2_DEC)) u_lane (
      .aclk      (aclk),
      .areset    (areset),
      .derand    (cfg_derand),
      .offset_bin(cfg_offset_bin),
      .first     (first1),
      .shift     (d2),
      .dat       (adc_dat[c*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
      .res       (res[c*LANE_W +: LANE_W])
    );
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      m_axis.tvalid    <= 1'b0;
      m_axis.tdata     <= '0;
      sts_overflow_cnt <= '0;
    end else begin
      if (load) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata  <= res;
      end else if (m_axis.tready) m_axis.tvalid <= 1'b0;
      if (done2 && m_axis.tvalid && !m_axis.tready && sts_overflow_cnt != '1)
        sts_overflow_cnt <= sts_overflow_cnt + 1'b1;
    end
endmodule

// File: tb/tb_axis_adc_multich.sv
// tb_axis_adc_multich: directed vectors and corner sequences for the multi-channel ADC front end
module tb_axis_adc_multich;
  logic aclk = 1'b0, areset = 1'b1, cfg_derand = 1'b0, cfg_offset_bin = 1'b0;
  logic [3:0] cfg_log2_dec = 4'd0;
  logic [27:0] adc_dat = '0;
  logic adc_csn;
  logic [31:0] sts_overflow_cnt;
  int nvec = 0, errs = 0, pulses;
  typedef struct {
    logic derand, offb;
    logic [13:0] r0, r1;
    logic [15:0] e0, e1;
  } vec_t;
  vec_t tbl[7];
  axis_adc_multich_if #(.N_CH(2)) m_axis ();
  axis_adc_multich #(.ADC_DATA_WIDTH(14), .N_CH(2), .MAX_LOG2_DEC(8)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .cfg_derand      (cfg_derand),
    .cfg_offset_bin  (cfg_offset_bin),
    .cfg_log2_dec    (cfg_log2_dec),
    .adc_dat         (adc_dat),
    .adc_csn         (adc_csn),
    .m_axis          (m_axis),
    .sts_overflow_cnt(sts_overflow_cnt)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic do_reset();
    areset = 1'b1;
    #1;
    tick();
    areset = 1'b0;
  endtask
  task automatic put(input logic [13:0] c0, input logic [13:0] c1);
    adc_dat = {c1, c0};
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b0, 14'h0001, 14'h0002, 16'hFFFF, 16'h0002};
    tbl[1] = '{1'b1, 1'b0, 14'h0002, 14'h0001, 16'h0002, 16'hFFFF};
    tbl[2] = '{1'b0, 1'b1, 14'h2000, 14'h0000, 16'h0000, 16'hE000};
    tbl[3] = '{1'b0, 1'b1, 14'h3FFF, 14'h2000, 16'h1FFF, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 14'h0000, 14'h3FFF, 16'hE000, 16'h1FFF};
    tbl[5] = '{1'b0, 1'b0, 14'h1FFF, 14'h2000, 16'h1FFF, 16'hE000};
    tbl[6] = '{1'b1, 1'b1, 14'h0001, 14'h0000, 16'h1FFF, 16'hE000};
    m_axis.tready = 1'b1;
    #2;
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis.tdata), 64'd0);
    chk("rst_ovf", 64'(sts_overflow_cnt), 64'd0);
    chk("csn", 64'(adc_csn), 64'd1);
    // latency: sample at edge 1 visible after edge 3
    do_reset();
    cfg_derand = 1'b1;
    put(14'h0001, 14'h0002);
    tick();
    tick();
    chk("lat_early", 64'(m_axis.tvalid), 64'd0);
    tick();
    chk("lat_valid", 64'(m_axis.tvalid), 64'd1);
    chk("lat_data", 64'(m_axis.tdata), {32'd0, 16'h0002, 16'hFFFF});
    for (int i = 0; i < 7; i++) begin
      cfg_derand = tbl[i].derand;
      cfg_offset_bin = tbl[i].offb;
      put(tbl[i].r0, tbl[i].r1);
      repeat (3) tick();
      chk($sformatf("vec%0d_valid", i), 64'(m_axis.tvalid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(m_axis.tdata), {32'd0, tbl[i].e1, tbl[i].e0});
    end
    // decimation by 4
    cfg_derand = 1'b0;
    cfg_offset_bin = 1'b0;
    cfg_log2_dec = 4'd2;
    do_reset();
    put(14'd1, 14'h3FFF); tick();
    put(14'd2, 14'h3FFF); tick();
    put(14'd3, 14'h3FFF); tick();
    put(14'd5, 14'h3FFE); tick();
    put(14'd4, 14'd4);
    tick();
    chk("dec_gap", 64'(m_axis.tvalid), 64'd0);
    tick();
    chk("dec_valid", 64'(m_axis.tvalid), 64'd1);
    chk("dec_data", 64'(m_axis.tdata), {32'd0, 16'hFFFE, 16'h0002});
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pulses += int'(m_axis.tvalid);
    end
    chk("dec_rate", 64'(pulses), 64'd2);
    chk("dec_data2", 64'(m_axis.tdata), {32'd0, 16'd4, 16'd4});
    // D change mid-window takes effect next window
    do_reset();
    put(14'd4, 14'd4); tick();
    tick();
    cfg_log2_dec = 4'd0;
    put(14'd8, 14'd8); tick();
    tick();
    put(14'd9, 14'd9);
    tick();
    tick();
    chk("dchg_valid", 64'(m_axis.tvalid), 64'd1);
    chk("dchg_avg", 64'(m_axis.tdata), {32'd0, 16'd6, 16'd6});
    tick();
    chk("dchg_next_valid", 64'(m_axis.tvalid), 64'd1);
    chk("dchg_next_data", 64'(m_axis.tdata), {32'd0, 16'd9, 16'd9});
    tick();
    chk("dchg_stream", 64'(m_axis.tvalid), 64'd1);
    // oversized D clamps to 8
    cfg_log2_dec = 4'd15;
    do_reset();
    put(14'd3, 14'd3);
    repeat (257) tick();
    chk("clamp_gap", 64'(m_axis.tvalid), 64'd0);
    tick();
    chk("clamp_valid", 64'(m_axis.tvalid), 64'd1);
    chk("clamp_data", 64'(m_axis.tdata), {32'd0, 16'd3, 16'd3});
    // back-pressure: ten results, first held, nine dropped
    cfg_log2_dec = 4'd0;
    m_axis.tready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      put(14'(i + 1), 14'(100 + i));
      tick();
    end
    chk("bp_valid", 64'(m_axis.tvalid), 64'd1);
    chk("bp_hold", 64'(m_axis.tdata), {32'd0, 16'd100, 16'd1});
    chk("bp_ovf", 64'(sts_overflow_cnt), 64'd9);
    m_axis.tready = 1'b1;
    put(14'd13, 14'd112);
    tick();
    chk("bp_resume_valid", 64'(m_axis.tvalid), 64'd1);
    chk("bp_resume_data", 64'(m_axis.tdata), {32'd0, 16'd110, 16'd11});
    chk("bp_resume_ovf", 64'(sts_overflow_cnt), 64'd9);
    repeat (3) tick();
    chk("bp_final_ovf", 64'(sts_overflow_cnt), 64'd9);
    // async reset mid-window
    m_axis.tready = 1'b0;
    do_reset();
    put(14'd7, 14'd7);
    repeat (5) tick();
    cfg_log2_dec = 4'd2;
    put(14'd100, 14'd100);
    repeat (2) tick();
    chk("rstm_pre_valid", 64'(m_axis.tvalid), 64'd1);
    chk("rstm_pre_ovf", 64'(sts_overflow_cnt), 64'd4);
    areset = 1'b1;
    #1;
    chk("rstm_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rstm_tdata", 64'(m_axis.tdata), 64'd0);
    chk("rstm_ovf", 64'(sts_overflow_cnt), 64'd0);
    tick();
    areset = 1'b0;
    m_axis.tready = 1'b1;
    put(14'd1, 14'd1);
    repeat (5) tick();
    chk("rstm_post_gap", 64'(m_axis.tvalid), 64'd0);
    tick();
    chk("rstm_post_valid", 64'(m_axis.tvalid), 64'd1);
    chk("rstm_post_data", 64'(m_axis.tdata), {32'd0, 16'd1, 16'd1});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
